// File: rtl/ysyx_25040101_ifu.sv
// rtl/ysyx_25040101_ifu.sv - instruction fetch unit: PC, single-outstanding imem fetch, decode handoff
// Redirects, stale-response draining and misaligned/bus-error/timeout faults are handled here.
module ysyx_25040101_ifu #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMER_W        = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        imem_rsp_err_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_fault_o,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   state_t             state, state_n;
   logic [31:0]        pc, pc_n;
   logic               drop, drop_n;
   logic [TIMER_W-1:0] timer, timer_n;
   logic [31:0]        inst_q, inst_n;
   logic [31:0]        ipc_q, ipc_n;
   logic               fault_q, fault_n;
   logic               misaligned;
   logic               timeout_hit;

   assign misaligned  = (pc[1:0] != 2'b00);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !drop && (timer == TIMER_LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         drop    <= 1'b0;
         timer   <= '0;
         inst_q  <= 32'd0;
         ipc_q   <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         drop    <= drop_n;
         timer   <= timer_n;
         inst_q  <= inst_n;
         ipc_q   <= ipc_n;
         fault_q <= fault_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      drop_n  = drop;
      timer_n = timer;
      inst_n  = inst_q;
      ipc_n   = ipc_q;
      fault_n = fault_q;
      case (state)
         S_REQ: begin
            if (redirect_valid_i) pc_n = redirect_pc_i;
            if (misaligned) begin
               if (!redirect_valid_i) begin
                  inst_n  = 32'd0;
                  ipc_n   = pc;
                  fault_n = 1'b1;
                  state_n = S_HOLD;
               end
            end else if (imem_req_ready_i) begin
               // A redirect racing the accept leaves that response to be drained.
               state_n = S_WAIT;
               timer_n = '0;
               drop_n  = redirect_valid_i;
            end
         end
         S_WAIT: begin
            if (!drop) timer_n = timer + TIMER_W'(1);
            if (redirect_valid_i) pc_n = redirect_pc_i;
            if (imem_rsp_valid_i) begin
               if (drop) begin
                  drop_n  = 1'b0;
                  state_n = S_REQ;
               end else if (redirect_valid_i) begin
                  state_n = S_REQ;
               end else begin
                  inst_n  = imem_rsp_data_i;
                  ipc_n   = pc;
                  fault_n = imem_rsp_err_i;
                  pc_n    = pc + 32'd4;
                  state_n = S_HOLD;
               end
            end else if (redirect_valid_i) begin
               drop_n = 1'b1;
            end else if (timeout_hit) begin
               inst_n  = 32'd0;
               ipc_n   = pc;
               fault_n = 1'b1;
               pc_n    = pc + 32'd4;
               drop_n  = 1'b1;
               state_n = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid_i) pc_n = redirect_pc_i;
            if (inst_ready_i || redirect_valid_i) state_n = drop ? S_WAIT : S_REQ;
         end
         default: state_n = S_REQ;
      endcase
   end

   assign imem_req_valid_o = rst_n_i && (state == S_REQ) && !misaligned;
   assign imem_req_addr_o  = pc;
   assign inst_valid_o     = rst_n_i && (state == S_HOLD);
   assign inst_o           = inst_q;
   assign inst_pc_o        = ipc_q;
   assign inst_fault_o     = rst_n_i && fault_q;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// tb/tb_ysyx_25040101_ifu.sv - directed plus randomized bench for the fetch unit
// Random phase checks the delivered stream against an address-level PC/memory model.
module tb_ysyx_25040101_ifu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        inst_fault;
   logic        redir;
   logic [31:0] redir_pc;

   int vec_cnt = 0;
   int err_cnt = 0;

   ysyx_25040101_ifu #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYCLES(4), .TIMER_W(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .imem_rsp_err_i(rsp_err),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst),
      .inst_pc_o(inst_pc), .inst_fault_o(inst_fault),
      .redirect_valid_i(redir), .redirect_pc_i(redir_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got expired want finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_reqv"}, req_valid, 0);
      chk({tag, "_instv"}, inst_valid, 0);
      chk({tag, "_fault"}, inst_fault, 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_pc"}, inst_pc, 0);
   endtask

   task automatic chk_hold(input string tag, input logic [31:0] i, input logic [31:0] p, input logic f);
      chk({tag, "_v"}, inst_valid, 1);
      chk({tag, "_inst"}, inst, i);
      chk({tag, "_pc"}, inst_pc, p);
      chk({tag, "_fault"}, inst_fault, f);
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return ^a[5:2];
   endfunction

   task automatic accept;
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_pc, out_addr, prev_pc, prev_inst;
      logic        outst, prev_kill, prev_hold, deliver;
      int          cnt, idle;

      req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
      inst_ready = 0; redir = 0; redir_pc = 0;

      // reset and release
      tick; tick;
      chk_zero("rst");
      rst_n = 1'b1;
      tick;
      chk("rel_reqv", req_valid, 1);
      chk("rel_addr", req_addr, 32'h8000_0000);

      // normal fetch with delayed grant, delayed response, stalled decode
      for (int i = 0; i < 2; i++) begin
         chk("nf_reqv", req_valid, 1);
         tick;
      end
      accept;
      for (int i = 0; i < 2; i++) begin
         chk("nf_wait_reqv", req_valid, 0);
         chk("nf_wait_instv", inst_valid, 0);
         tick;
      end
      rsp_valid = 1; rsp_data = 32'h0050_0093; rsp_err = 0;
      tick;
      rsp_valid = 0;
      for (int i = 0; i < 4; i++) begin
         chk_hold("nf_hold", 32'h0050_0093, 32'h8000_0000, 1'b0);
         if (i < 3) tick;
      end
      inst_ready = 1; tick; inst_ready = 0;
      chk("nf_next_reqv", req_valid, 1);
      chk("nf_next_addr", req_addr, 32'h8000_0004);

      // redirect in S_WAIT, response later
      accept;
      redir = 1; redir_pc = 32'h8000_0100;
      tick;
      redir = 0;
      chk("rw_instv0", inst_valid, 0);
      tick;
      chk("rw_instv1", inst_valid, 0);
      rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
      tick;
      rsp_valid = 0;
      chk("rw_instv2", inst_valid, 0);
      chk("rw_reqv", req_valid, 1);
      chk("rw_addr", req_addr, 32'h8000_0100);

      // redirect and response in the same cycle
      accept;
      redir = 1; redir_pc = 32'h8000_0200; rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
      tick;
      redir = 0; rsp_valid = 0;
      chk("rs_instv", inst_valid, 0);
      chk("rs_reqv", req_valid, 1);
      chk("rs_addr", req_addr, 32'h8000_0200);
      tick;
      chk("rs_instv1", inst_valid, 0);

      // timeout after four silent wait cycles
      accept;
      for (int i = 0; i < 4; i++) begin
         chk("to_wait_instv", inst_valid, 0);
         tick;
      end
      chk_hold("to_hold", 32'd0, 32'h8000_0200, 1'b1);
      inst_ready = 1; tick; inst_ready = 0;
      for (int i = 0; i < 6; i++) begin
         chk("to_drain_reqv", req_valid, 0);
         chk("to_drain_instv", inst_valid, 0);
         tick;
      end
      rsp_valid = 1; rsp_data = 32'h1111_2222;
      tick;
      rsp_valid = 0;
      chk("to_next_reqv", req_valid, 1);
      chk("to_next_addr", req_addr, 32'h8000_0204);

      // misaligned redirect
      redir = 1; redir_pc = 32'h8000_0102;
      tick;
      redir = 0; req_ready = 1;
      chk("ma_reqv0", req_valid, 0);
      tick;
      req_ready = 0;
      chk("ma_reqv1", req_valid, 0);
      chk_hold("ma_hold", 32'd0, 32'h8000_0102, 1'b1);

      // deliver plus redirect to the top of the address space
      inst_ready = 1; redir = 1; redir_pc = 32'hFFFF_FFFC;
      tick;
      inst_ready = 0; redir = 0;
      chk("be_reqv", req_valid, 1);
      chk("be_addr", req_addr, 32'hFFFF_FFFC);
      accept;
      rsp_valid = 1; rsp_data = 32'h1234_5678; rsp_err = 1;
      tick;
      rsp_valid = 0; rsp_err = 0;
      chk_hold("be_hold", 32'h1234_5678, 32'hFFFF_FFFC, 1'b1);
      inst_ready = 1; tick; inst_ready = 0;
      chk("wrap_addr", req_addr, 32'h0000_0000);
      accept;

      // reset during S_WAIT, stray response afterwards
      rst_n = 0;
      tick;
      chk_zero("mrst");
      rsp_valid = 1; rsp_data = 32'hBAD0_BAD0;
      tick;
      rst_n = 1;
      tick;
      chk("mrst_reqv", req_valid, 1);
      chk("mrst_addr", req_addr, 32'h8000_0000);
      chk("mrst_instv", inst_valid, 0);
      rsp_valid = 0;
      tick;
      chk("mrst_instv1", inst_valid, 0);

      // randomized traffic against the address-level model
      exp_pc = 32'h8000_0000;
      outst = 0; out_addr = 0; cnt = 0; idle = 0;
      prev_kill = 0; prev_hold = 0; prev_pc = 0; prev_inst = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_kill) chk("rnd_kill", inst_valid, 0);
         if (prev_hold) begin
            chk("rnd_hold_v", inst_valid, 1);
            chk("rnd_hold_pc", inst_pc, prev_pc);
            chk("rnd_hold_inst", inst, prev_inst);
         end
         if (outst) chk("rnd_one_outstanding", req_valid, 0);

         rsp_valid = 0; rsp_data = $urandom; rsp_err = 1'($urandom);
         if (outst) begin
            if (cnt == 0) begin
               rsp_valid = 1;
               rsp_data  = mem_data(out_addr);
               rsp_err   = mem_err(out_addr);
               outst     = 0;
            end else begin
               cnt--;
            end
         end
         req_ready  = !outst && ($urandom_range(0, 1) == 1);
         inst_ready = ($urandom_range(0, 1) == 1);
         redir      = ($urandom_range(0, 15) == 0);
         redir_pc   = $urandom & 32'hFFFF_FFFC;

         deliver = inst_valid && inst_ready;
         if (deliver) begin
            chk("rnd_pc", inst_pc, exp_pc);
            chk("rnd_inst", inst, mem_data(exp_pc));
            chk("rnd_fault", inst_fault, mem_err(exp_pc));
            idle = 0;
         end else begin
            idle++;
         end
         if (redir) exp_pc = redir_pc;
         else if (deliver) exp_pc = exp_pc + 32'd4;

         if (req_valid && req_ready) begin
            outst    = 1;
            out_addr = req_addr;
            cnt      = $urandom_range(0, 3);
         end
         prev_kill = inst_valid && (inst_ready || redir);
         prev_hold = inst_valid && !inst_ready && !redir;
         prev_pc   = inst_pc;
         prev_inst = inst;
         if (idle > 200) begin
            chk("rnd_progress", idle, 0);
            break;
         end
         tick;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
